// File: rtl/ha_stim_checker.sv
// ha_stim_checker: drives all four half-adder vectors, checks sum/carry, counts mismatches (optional HA_CHK_FAILCAP_EN adds first-fail capture)
module ha_stim_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    output logic             a_o,
    output logic             b_o,
    input  logic             sum_i,
    input  logic             carry_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic [1:0]       vec_idx_o
`ifdef HA_CHK_FAILCAP_EN
    ,
    output logic             fail_valid_o,
    output logic [1:0]       fail_vec_o
`endif
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int PW = $clog2(NUM_PASSES + 1);

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   settle_q;
    logic [PW-1:0]   pass_q;
    logic            mismatch, last_vec, settle_last, accept;
    logic [ERR_W-1:0] err_nxt;

    assign {a_o, b_o}  = vec_idx_o;
    assign accept      = state_q == IDLE && start_i;
    assign settle_last = settle_q == SW'(SETTLE_CYCLES - 1);
    assign last_vec    = vec_idx_o == 2'd3 && pass_q == PW'(NUM_PASSES - 1);
    assign mismatch    = sum_i != (a_o ^ b_o) || carry_i != (a_o & b_o);
    assign err_nxt     = mismatch && err_cnt_o != '1 ? err_cnt_o + ERR_W'(1) : err_cnt_o;
    assign busy_o      = state_q == DRIVE || state_q == SETTLE || state_q == CHECK;
    assign done_o      = state_q == DONE;

    // next-state sequencing through drive/settle/check per vector
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_i ? DRIVE : IDLE;
            DRIVE:   state_d = SETTLE;
            SETTLE:  state_d = settle_last ? CHECK : SETTLE;
            CHECK:   state_d = last_vec ? DONE : DRIVE;
            default: state_d = IDLE;
        endcase
    end

    // state, vector/pass/settle counters, error count and verdict
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            settle_q     <= '0;
            pass_q       <= '0;
            vec_idx_o    <= '0;
            err_cnt_o    <= '0;
            pass_o       <= 1'b0;
`ifdef HA_CHK_FAILCAP_EN
            fail_valid_o <= 1'b0;
            fail_vec_o   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            settle_q <= state_q == SETTLE ? settle_q + SW'(1) : '0;
            if (accept) begin
                pass_q       <= '0;
                vec_idx_o    <= '0;
                err_cnt_o    <= '0;
                pass_o       <= 1'b0;
`ifdef HA_CHK_FAILCAP_EN
                fail_valid_o <= 1'b0;
                fail_vec_o   <= '0;
`endif
            end else if (state_q == CHECK) begin
                err_cnt_o <= err_nxt;
                vec_idx_o <= vec_idx_o + 2'd1;
                if (vec_idx_o == 2'd3)
                    pass_q <= pass_q + PW'(1);
                if (last_vec)
                    pass_o <= err_nxt == '0;
`ifdef HA_CHK_FAILCAP_EN
                if (mismatch && !fail_valid_o) begin
                    fail_valid_o <= 1'b1;
                    fail_vec_o   <= vec_idx_o;
                end
`endif
            end
        end
    end
endmodule
